// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: datapath widths, ALU opcode
// encodings and operand-source select codes.
package ex_operand_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;

  // ALU opcodes; ADD is the all-zero reset value.
  localparam logic [OP_W-1:0] AluAdd  = 4'b0000;
  localparam logic [OP_W-1:0] AluSub  = 4'b0001;
  localparam logic [OP_W-1:0] AluAnd  = 4'b0010;
  localparam logic [OP_W-1:0] AluOr   = 4'b0011;
  localparam logic [OP_W-1:0] AluXor  = 4'b0100;
  localparam logic [OP_W-1:0] AluSll  = 4'b0101;
  localparam logic [OP_W-1:0] AluSrl  = 4'b0110;
  localparam logic [OP_W-1:0] AluSlt  = 4'b0111;
  localparam logic [OP_W-1:0] AluSltu = 4'b1000;
  localparam logic [OP_W-1:0] AluSra  = 4'b1001;

  // Operand 0 source; both 2'b10 and 2'b11 select zero.
  localparam logic [1:0] Src1Rs1  = 2'b00;
  localparam logic [1:0] Src1Pc   = 2'b01;
  localparam logic [1:0] Src1Zero = 2'b10;

  // Operand 1 source.
  localparam logic Src2Rs2 = 1'b0;
  localparam logic Src2Imm = 1'b1;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of the operand stage's decode-side, forwarding and ALU-side signals.
//   master : environment (decode, forwarding sources, ALU consumer)
//   slave  : the operand stage itself
interface ex_operand_stage_if
  import ex_operand_stage_pkg::*;
();
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rd_addr;
  logic [OP_W-1:0]   id_alu_op;
  logic [1:0]        id_src1_sel;
  logic              id_src2_sel;
  logic              fwd_mem_en;
  logic [REG_AW-1:0] fwd_mem_rd;
  logic [XLEN-1:0]   fwd_mem_data;
  logic              fwd_wb_en;
  logic [REG_AW-1:0] fwd_wb_rd;
  logic [XLEN-1:0]   fwd_wb_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   alu_in0;
  logic [XLEN-1:0]   alu_in1;
  logic [OP_W-1:0]   alu_op;
  logic [REG_AW-1:0] ex_rd_addr;
  logic [XLEN-1:0]   ex_store_data;

  modport master (
    output flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_alu_op, id_src1_sel, id_src2_sel,
           fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data, ex_ready,
    input  id_ready, ex_valid, alu_in0, alu_in1, alu_op, ex_rd_addr, ex_store_data
  );

  modport slave (
    input  flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_alu_op, id_src1_sel, id_src2_sel,
           fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data, ex_ready,
    output id_ready, ex_valid, alu_in0, alu_in1, alu_op, ex_rd_addr, ex_store_data
  );
endinterface

// File: rtl/ex_operand_stage_fwd_select.sv
// Combinational forwarding resolver for one source operand.
//   addr_i          : source register address (x0 always reads zero)
//   rf_data_i       : fallback value (regfile read or currently held value)
//   mem_*_i, wb_*_i : MEM / WB write-back ports; MEM has priority
//   data_o          : resolved operand value
module ex_operand_stage_fwd_select
  import ex_operand_stage_pkg::*;
(
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              mem_en_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (addr_i == '0) begin
      data_o = '0;
    end else if (mem_en_i && (mem_rd_i == addr_i)) begin
      data_o = mem_data_i;
    end else if (wb_en_i && (wb_rd_i == addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decoded operands with
// RAW forwarding, keeps re-forwarding held operands while stalled, and
// presents ALU operands through combinational muxes on the registered fields.
//   clk, rst : clock, synchronous active-high reset
//   bus      : decode handshake/fields, MEM/WB forwarding, ALU-side outputs
module ex_operand_stage
  import ex_operand_stage_pkg::*;
(
  input logic               clk,
  input logic               rst,
  ex_operand_stage_if.slave bus
);

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, imm_q, rs1_val_q, rs2_val_q;
  logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        src1_sel_q;
  logic              src2_sel_q;

  logic              id_ready;
  logic              hold;
  logic              load;
  logic [REG_AW-1:0] rs1_addr_mux, rs2_addr_mux;
  logic [XLEN-1:0]   rs1_base_mux, rs2_base_mux;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

  assign id_ready = !valid_q || bus.ex_ready;
  assign hold     = valid_q && !bus.ex_ready;
  // Fields load even under flush; the cleared valid makes them don't-care.
  assign load     = bus.id_valid && id_ready;

  // One resolver per source, shared between capture and held re-forwarding.
  assign rs1_addr_mux = hold ? rs1_addr_q : bus.id_rs1_addr;
  assign rs2_addr_mux = hold ? rs2_addr_q : bus.id_rs2_addr;
  assign rs1_base_mux = hold ? rs1_val_q  : bus.id_rs1_data;
  assign rs2_base_mux = hold ? rs2_val_q  : bus.id_rs2_data;

  ex_operand_stage_fwd_select u_fwd_rs1 (
    .addr_i     (rs1_addr_mux),
    .rf_data_i  (rs1_base_mux),
    .mem_en_i   (bus.fwd_mem_en),
    .mem_rd_i   (bus.fwd_mem_rd),
    .mem_data_i (bus.fwd_mem_data),
    .wb_en_i    (bus.fwd_wb_en),
    .wb_rd_i    (bus.fwd_wb_rd),
    .wb_data_i  (bus.fwd_wb_data),
    .data_o     (rs1_fwd)
  );

  ex_operand_stage_fwd_select u_fwd_rs2 (
    .addr_i     (rs2_addr_mux),
    .rf_data_i  (rs2_base_mux),
    .mem_en_i   (bus.fwd_mem_en),
    .mem_rd_i   (bus.fwd_mem_rd),
    .mem_data_i (bus.fwd_mem_data),
    .wb_en_i    (bus.fwd_wb_en),
    .wb_rd_i    (bus.fwd_wb_rd),
    .wb_data_i  (bus.fwd_wb_data),
    .data_o     (rs2_fwd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q       <= '0;
      op_q       <= AluAdd;
      src1_sel_q <= Src1Rs1;
      src2_sel_q <= Src2Rs2;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (bus.ex_ready) begin
        valid_q <= 1'b0;
      end

      if (hold) begin
        rs1_val_q <= rs1_fwd;
        rs2_val_q <= rs2_fwd;
      end else if (load) begin
        pc_q       <= bus.id_pc;
        imm_q      <= bus.id_imm;
        rs1_val_q  <= rs1_fwd;
        rs2_val_q  <= rs2_fwd;
        rs1_addr_q <= bus.id_rs1_addr;
        rs2_addr_q <= bus.id_rs2_addr;
        rd_q       <= bus.id_rd_addr;
        op_q       <= bus.id_alu_op;
        src1_sel_q <= bus.id_src1_sel;
        src2_sel_q <= bus.id_src2_sel;
      end
    end
  end

  always_comb begin
    bus.alu_in0 = '0;
    if (src1_sel_q == Src1Rs1) begin
      bus.alu_in0 = rs1_val_q;
    end else if (src1_sel_q == Src1Pc) begin
      bus.alu_in0 = pc_q;
    end
  end

  assign bus.alu_in1       = (src2_sel_q == Src2Imm) ? imm_q : rs2_val_q;
  assign bus.id_ready      = id_ready;
  assign bus.ex_valid      = valid_q;
  assign bus.alu_op        = op_q;
  assign bus.ex_rd_addr    = rd_q;
  assign bus.ex_store_data = rs2_val_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [3:0]  op;
    logic [1:0]  s1;
    logic        s2;
  } ent_t;

  ent_t m;
  bit   m_valid;
  bit   m_known;  // fields are defined (not left over from a flushed capture)

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 0;
    if (bus.fwd_mem_en && bus.fwd_mem_rd == a) return bus.fwd_mem_data;
    if (bus.fwd_wb_en && bus.fwd_wb_rd == a) return bus.fwd_wb_data;
    return rf;
  endfunction

  // Advance the model by one edge using the inputs presented now.
  task automatic model_step();
    bit accept;
    if (rst) begin
      m = '{default: 0};
      m_valid = 0;
      m_known = 1;
      return;
    end
    accept = !m_valid || bus.ex_ready;
    if (m_valid && !bus.ex_ready) begin
      m.rs1v = resolve(m.rs1a, m.rs1v);
      m.rs2v = resolve(m.rs2a, m.rs2v);
    end else if (bus.id_valid) begin
      m.pc   = bus.id_pc;
      m.imm  = bus.id_imm;
      m.rs1a = bus.id_rs1_addr;
      m.rs2a = bus.id_rs2_addr;
      m.rs1v = resolve(bus.id_rs1_addr, bus.id_rs1_data);
      m.rs2v = resolve(bus.id_rs2_addr, bus.id_rs2_data);
      m.rd   = bus.id_rd_addr;
      m.op   = bus.id_alu_op;
      m.s1   = bus.id_src1_sel;
      m.s2   = bus.id_src2_sel;
      m_known = !bus.flush;
    end
    if (bus.flush) m_valid = 0;
    else if (bus.id_valid && accept) m_valid = 1;
    else if (bus.ex_ready) m_valid = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] e0;
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("id_ready", 32'(bus.id_ready), 32'(!m_valid || bus.ex_ready));
    if (m_known) begin
      case (m.s1)
        2'b00:   e0 = m.rs1v;
        2'b01:   e0 = m.pc;
        default: e0 = 0;
      endcase
      chk("alu_in0", bus.alu_in0, e0);
      chk("alu_in1", bus.alu_in1, m.s2 ? m.imm : m.rs2v);
      chk("alu_op", 32'(bus.alu_op), 32'(m.op));
      chk("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(m.rd));
      chk("ex_store_data", bus.ex_store_data, m.rs2v);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_idle();
    bus.flush = 0; bus.id_valid = 0; bus.id_pc = 0;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_imm = 0; bus.id_rd_addr = 0; bus.id_alu_op = 0; bus.id_src1_sel = 0;
    bus.id_src2_sel = 0; bus.fwd_mem_en = 0; bus.fwd_mem_rd = 0; bus.fwd_mem_data = 0;
    bus.fwd_wb_en = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 0; bus.ex_ready = 1;
  endtask

  task automatic randomize_inputs();
    bus.flush        = ($urandom_range(0, 15) == 0);
    bus.id_valid     = ($urandom_range(0, 3) != 0);
    bus.id_pc        = $urandom;
    bus.id_rs1_addr  = 5'($urandom_range(0, 7));
    bus.id_rs2_addr  = 5'($urandom_range(0, 7));
    bus.id_rs1_data  = $urandom;
    bus.id_rs2_data  = $urandom;
    bus.id_imm       = $urandom;
    bus.id_rd_addr   = 5'($urandom);
    bus.id_alu_op    = 4'($urandom_range(0, 9));
    bus.id_src1_sel  = 2'($urandom);
    bus.id_src2_sel  = 1'($urandom);
    bus.fwd_mem_en   = 1'($urandom);
    bus.fwd_mem_rd   = 5'($urandom_range(0, 7));
    bus.fwd_mem_data = $urandom;
    bus.fwd_wb_en    = 1'($urandom);
    bus.fwd_wb_rd    = 5'($urandom_range(0, 7));
    bus.fwd_wb_data  = $urandom;
    bus.ex_ready     = ($urandom_range(0, 2) != 0);
    rst              = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    m = '{default: 0};
    m_valid = 0;
    m_known = 0;
    set_idle();

    // Reset, then idle.
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    chk("idle_ex_valid", 32'(bus.ex_valid), 0);
    chk("idle_id_ready", 32'(bus.id_ready), 1);
    chk("idle_alu_in0", bus.alu_in0, 0);
    chk("idle_alu_in1", bus.alu_in1, 0);

    // Basic load: rs1=x3 (rf 5), imm 7, ADD.
    bus.id_valid = 1; bus.id_rs1_addr = 3; bus.id_rs1_data = 5;
    bus.id_imm = 7; bus.id_src2_sel = Src2Imm; bus.id_alu_op = AluAdd; bus.id_rd_addr = 9;
    tick();
    chk("load_ex_valid", 32'(bus.ex_valid), 1);
    chk("load_alu_in0", bus.alu_in0, 5);
    chk("load_alu_in1", bus.alu_in1, 7);
    chk("load_id_ready", 32'(bus.id_ready), 1);

    // MEM forwarding beats WB; x0 never forwards.
    bus.id_rs1_addr = 4; bus.id_rs1_data = 1;
    bus.fwd_mem_en = 1; bus.fwd_mem_rd = 4; bus.fwd_mem_data = 32'h10;
    bus.fwd_wb_en = 1; bus.fwd_wb_rd = 4; bus.fwd_wb_data = 32'h20;
    tick();
    chk("fwd_mem_prio", bus.alu_in0, 32'h10);
    bus.id_rs1_addr = 0; bus.id_rs1_data = 32'h55; bus.fwd_mem_rd = 0; bus.fwd_wb_rd = 0;
    tick();
    chk("fwd_x0_zero", bus.alu_in0, 0);

    // Stall with rs2=x5, then WB writes x5 while held.
    set_idle();
    bus.id_valid = 1; bus.id_rs2_addr = 5; bus.id_rs2_data = 32'h11; bus.id_src2_sel = Src2Rs2;
    tick();
    bus.ex_ready = 0; bus.id_rs2_data = 32'h22; bus.id_pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_id_ready", 32'(bus.id_ready), 0);
      chk("stall_alu_in1", bus.alu_in1, 32'h11);
    end
    bus.fwd_wb_en = 1; bus.fwd_wb_rd = 5; bus.fwd_wb_data = 32'h99;
    tick();
    chk("held_fwd_store", bus.ex_store_data, 32'h99);
    chk("held_fwd_in1", bus.alu_in1, 32'h99);
    bus.fwd_wb_en = 0;

    // Flush wins over a simultaneous load.
    bus.ex_ready = 1; bus.id_valid = 1; bus.flush = 1;
    tick();
    chk("flush_ex_valid", 32'(bus.ex_valid), 0);
    bus.flush = 0;

    // Reset during a stall.
    bus.id_rs1_addr = 2; bus.id_rs1_data = 32'hABC;
    tick();
    bus.ex_ready = 0; rst = 1;
    tick();
    chk("rst_stall_valid", 32'(bus.ex_valid), 0);
    chk("rst_stall_in0", bus.alu_in0, 0);
    rst = 0;
    bus.ex_ready = 1;

    // Back-to-back stream with operand 0 from PC.
    bus.id_valid = 1; bus.id_src1_sel = Src1Pc;
    for (int i = 0; i < 4; i++) begin
      bus.id_pc = 32'h1000 + 32'(4 * i);
      tick();
      chk("b2b_ex_valid", 32'(bus.ex_valid), 1);
      chk("b2b_alu_in0", bus.alu_in0, 32'h1000 + 32'(4 * i));
    end
    bus.id_valid = 0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      tick();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
